// File: rtl/usb_boot_sup_pkg.sv
// Shared types, constants and helpers for the USB host-presence watchdog and
// warm-boot sequencer.
package usb_boot_sup_pkg;

  localparam int FRAME_W = 11;

  typedef logic [1:0] image_idx_t;

  typedef enum logic [1:0] {
    ST_ATTACH = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ARM    = 2'd2,
    ST_BOOT   = 2'd3
  } sup_state_e;

  function automatic longint ms_to_cycles(input longint clk_hz, input longint ms);
    return (clk_hz / 64'sd1000) * ms;
  endfunction

endpackage

// File: rtl/usb_boot_sup_frame_check.sv
// SOF sequence checker: tracks the previous frame number, flags out-of-order
// SOFs and keeps a saturating error count.
module usb_boot_sup_frame_check
  import usb_boot_sup_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               sof_valid,
  input  logic [FRAME_W-1:0] frame_index,
  output logic               sof_ok,
  output logic [7:0]         err_count
);

  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(32'd1);

  logic [FRAME_W-1:0] prev_r;
  logic               first_r;
  logic [FRAME_W-1:0] expect_s;

  assign expect_s = prev_r + FRAME_ONE;

  // The first SOF after reset is trusted; later ones must advance by one (mod 2048).
  always_comb begin
    sof_ok = 1'b0;
    if (sof_valid) begin
      sof_ok = first_r || (frame_index == expect_s);
    end else begin
      sof_ok = 1'b0;
    end
  end

  // Previous-frame tracking and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r    <= '0;
      first_r   <= 1'b1;
      err_count <= 8'd0;
    end else if (sof_valid) begin
      prev_r  <= frame_index;
      first_r <= 1'b0;
      if (!sof_ok && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/usb_boot_supervisor.sv
// Host-presence watchdog and SB_WARMBOOT sequencer (select held before boot).
// Optional SOF sequence checking is enabled by USB_BOOT_SUP_FRAME_CHECK_EN.
module usb_boot_supervisor
  import usb_boot_sup_pkg::*;
#(
  parameter int CLK_HZ            = 48000000,
  parameter int ATTACH_TIMEOUT_MS = 3000,
  parameter int TIMEOUT_MS        = 1000,
  parameter int NUM_IMAGES        = 4,
  parameter int DEFAULT_IMAGE     = 1,
  parameter int SETUP_CYCLES      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sof_valid,
  input  logic [FRAME_W-1:0] frame_index,
  input  logic               supervise_en,
  input  logic               boot_req,
  input  logic [1:0]         boot_image,
  output logic               boot_ack,
  output logic               boot_nak,
  output logic               host_present,
  output logic [1:0]         warmboot_s,
  output logic               warmboot_boot,
  output logic [7:0]         frame_err_count
);

  localparam longint ATTACH_CYC  = ms_to_cycles(longint'(CLK_HZ), longint'(ATTACH_TIMEOUT_MS));
  localparam longint TIMEOUT_CYC = ms_to_cycles(longint'(CLK_HZ), longint'(TIMEOUT_MS));
  localparam longint MAX_CYC     = (ATTACH_CYC > TIMEOUT_CYC) ? ATTACH_CYC : TIMEOUT_CYC;
  localparam int     TMR_W       = $clog2(MAX_CYC + 64'sd1);
  localparam int     SET_W       = $clog2(SETUP_CYCLES + 32'sd1);

  localparam logic [TMR_W-1:0] ATTACH_LAST  = TMR_W'(ATTACH_CYC - 64'sd1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 64'sd1);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(32'd1);
  localparam logic [TMR_W-1:0] TMR_MAX      = '1;
  localparam logic [SET_W-1:0] SET_LAST     = SET_W'(SETUP_CYCLES - 32'sd1);
  localparam logic [SET_W-1:0] SET_ONE      = SET_W'(32'd1);
  localparam logic [2:0]       NUM_IMG      = 3'(NUM_IMAGES);
  localparam image_idx_t       DEF_IMG      = image_idx_t'(DEFAULT_IMAGE);

  sup_state_e       state_r, state_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [SET_W-1:0] set_cnt_r, set_cnt_s;
  image_idx_t       image_r, image_s;
  logic             hp_r, hp_s;
  logic             ack_r, ack_s;
  logic             nak_r, nak_s;
  logic [1:0]       ws_r, ws_s;
  logic             wb_r, wb_s;
  logic             sof_ok_s;
  logic [7:0]       err_count_s;
  logic             req_ok_s;
  logic             timeout_s;

`ifdef USB_BOOT_SUP_FRAME_CHECK_EN
  usb_boot_sup_frame_check u_frame_check (
    .clk         (clk),
    .reset       (reset),
    .sof_valid   (sof_valid),
    .frame_index (frame_index),
    .sof_ok      (sof_ok_s),
    .err_count   (err_count_s)
  );
`else
  logic unused_frame_s;
  assign unused_frame_s = ^frame_index;
  assign sof_ok_s       = sof_valid;
  assign err_count_s    = 8'd0;
`endif

  assign req_ok_s  = ({1'b0, boot_image} < NUM_IMG);
  assign timeout_s = supervise_en &&
                     (((state_r == ST_ATTACH) && (timer_r == ATTACH_LAST)) ||
                      ((state_r == ST_ACTIVE) && (timer_r == TIMEOUT_LAST)));

  // Next state: request beats SOF, SOF beats timeout; ARM/BOOT ignore requests.
  always_comb begin
    state_s   = state_r;
    set_cnt_s = set_cnt_r;
    image_s   = image_r;
    hp_s      = hp_r;
    ack_s     = 1'b0;
    nak_s     = 1'b0;
    timer_s   = timer_r;
    ws_s      = 2'b00;
    wb_s      = 1'b0;
    case (state_r)
      ST_ATTACH, ST_ACTIVE: begin
        if (boot_req && req_ok_s) begin
          ack_s   = 1'b1;
          state_s = ST_ARM;
          image_s = boot_image;
        end else if (sof_ok_s) begin
          state_s = ST_ACTIVE;
          hp_s    = 1'b1;
        end else if (timeout_s) begin
          state_s = ST_ARM;
          image_s = DEF_IMG;
          hp_s    = 1'b0;
        end else begin
          state_s = state_r;
        end
        if (boot_req && !req_ok_s) begin
          nak_s = 1'b1;
        end else begin
          nak_s = 1'b0;
        end
      end
      ST_ARM: begin
        if (set_cnt_r == SET_LAST) begin
          state_s = ST_BOOT;
        end else begin
          set_cnt_s = set_cnt_r + SET_ONE;
        end
      end
      ST_BOOT: begin
        state_s = ST_BOOT;
      end
      default: begin
        state_s = ST_ATTACH;
      end
    endcase

    if (state_s != state_r) begin
      set_cnt_s = '0;
    end else begin
      set_cnt_s = set_cnt_s;
    end

    // Timer only runs while waiting for the host; it saturates rather than wraps.
    if ((state_s != state_r) || sof_ok_s || !supervise_en ||
        (state_r == ST_ARM) || (state_r == ST_BOOT)) begin
      timer_s = '0;
    end else if (timer_r != TMR_MAX) begin
      timer_s = timer_r + TMR_ONE;
    end else begin
      timer_s = timer_r;
    end

    if ((state_s == ST_ARM) || (state_s == ST_BOOT)) begin
      ws_s = image_s;
    end else begin
      ws_s = 2'b00;
    end
    wb_s = (state_s == ST_BOOT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_ATTACH;
      timer_r   <= '0;
      set_cnt_r <= '0;
      image_r   <= 2'b00;
      hp_r      <= 1'b0;
      ack_r     <= 1'b0;
      nak_r     <= 1'b0;
      ws_r      <= 2'b00;
      wb_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      set_cnt_r <= set_cnt_s;
      image_r   <= image_s;
      hp_r      <= hp_s;
      ack_r     <= ack_s;
      nak_r     <= nak_s;
      ws_r      <= ws_s;
      wb_r      <= wb_s;
    end
  end

  assign boot_ack        = ack_r;
  assign boot_nak        = nak_r;
  assign host_present    = hp_r;
  assign warmboot_s      = ws_r;
  assign warmboot_boot   = wb_r;
  assign frame_err_count = err_count_s;

endmodule

// File: tb/tb_usb_boot_supervisor.sv
// Directed self-checking bench for usb_boot_supervisor at CLK_HZ=1000
// (10-cycle SOF timeout, 20-cycle attach timeout, 4 setup cycles, 3 images).
module tb_usb_boot_supervisor;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof_valid;
  logic [10:0] frame_index;
  logic        supervise_en;
  logic        boot_req;
  logic [1:0]  boot_image;
  logic        boot_ack;
  logic        boot_nak;
  logic        host_present;
  logic [1:0]  warmboot_s;
  logic        warmboot_boot;
  logic [7:0]  frame_err_count;

  int          total = 0;
  int          bad   = 0;
  logic [10:0] frame_q = 11'd0;

  always #5 clk = ~clk;

  usb_boot_supervisor #(
    .CLK_HZ            (1000),
    .ATTACH_TIMEOUT_MS (20),
    .TIMEOUT_MS        (10),
    .NUM_IMAGES        (3),
    .DEFAULT_IMAGE     (1),
    .SETUP_CYCLES      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sof_valid       (sof_valid),
    .frame_index     (frame_index),
    .supervise_en    (supervise_en),
    .boot_req        (boot_req),
    .boot_image      (boot_image),
    .boot_ack        (boot_ack),
    .boot_nak        (boot_nak),
    .host_present    (host_present),
    .warmboot_s      (warmboot_s),
    .warmboot_boot   (warmboot_boot),
    .frame_err_count (frame_err_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sof_frame(input logic [10:0] f);
    sof_valid   = 1'b1;
    frame_index = f;
    tick(1);
    sof_valid   = 1'b0;
  endtask

  task automatic sof_next();
    sof_frame(frame_q);
    frame_q = frame_q + 11'd1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    sof_valid    = 1'b0;
    frame_index  = 11'd0;
    supervise_en = 1'b1;
    boot_req     = 1'b0;
    boot_image   = 2'd0;
    tick(2);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, boot_ack, boot_nak, host_present, warmboot_s, warmboot_boot, frame_err_count};
  endfunction

  initial begin
    do_reset();
    reset = 1'b0;
    #1;
    check_val("reset_outputs", outs(), 32'd0);

    // attach timeout
    do_reset();
    tick(19);
    check_val("attach_pre_s", 32'(warmboot_s), 32'd0);
    tick(1);
    check_val("attach_s", 32'(warmboot_s), 32'd1);
    check_val("attach_host", 32'(host_present), 32'd0);
    tick(3);
    check_val("attach_boot_early", 32'(warmboot_boot), 32'd0);
    tick(1);
    check_val("attach_boot", 32'(warmboot_boot), 32'd1);
    tick(10);
    check_val("attach_boot_hold", 32'({warmboot_s, warmboot_boot}), 32'd3);

    // keepalive then timeout
    do_reset();
    sof_next();
    check_val("keep_host_rise", 32'(host_present), 32'd1);
    for (int i = 0; i < 22; i++) begin
      tick(8);
      sof_next();
    end
    check_val("keep_active", 32'({host_present, warmboot_s, warmboot_boot}), 32'h8);
    tick(9);
    check_val("keep_gap9", 32'(warmboot_s), 32'd0);
    tick(1);
    check_val("keep_timeout_s", 32'(warmboot_s), 32'd1);
    check_val("keep_timeout_host", 32'(host_present), 32'd0);

    // explicit boot of image 2
    do_reset();
    sof_next();
    tick(2);
    boot_req   = 1'b1;
    boot_image = 2'd2;
    tick(1);
    boot_req   = 1'b0;
    check_val("req_ack", 32'({boot_ack, boot_nak}), 32'd2);
    check_val("req_s", 32'(warmboot_s), 32'd2);
    check_val("req_host", 32'(host_present), 32'd1);
    tick(1);
    check_val("req_ack_pulse", 32'(boot_ack), 32'd0);
    tick(2);
    check_val("req_boot_early", 32'(warmboot_boot), 32'd0);
    tick(1);
    check_val("req_boot", 32'(warmboot_boot), 32'd1);
    boot_req   = 1'b1;
    boot_image = 2'd0;
    tick(1);
    boot_req   = 1'b0;
    check_val("boot_ignores_req", 32'({boot_ack, boot_nak, warmboot_s}), 32'd2);

    // rejected image
    do_reset();
    sof_next();
    boot_req   = 1'b1;
    boot_image = 2'd3;
    tick(1);
    boot_req   = 1'b0;
    check_val("nak", 32'({boot_ack, boot_nak}), 32'd1);
    check_val("nak_stay", 32'({host_present, warmboot_s}), 32'd4);
    tick(1);
    check_val("nak_pulse", 32'(boot_nak), 32'd0);

    // request + SOF + timer at limit
    do_reset();
    sof_next();
    tick(9);
    boot_req    = 1'b1;
    boot_image  = 2'd0;
    sof_valid   = 1'b1;
    frame_index = frame_q;
    frame_q     = frame_q + 11'd1;
    tick(1);
    boot_req  = 1'b0;
    sof_valid = 1'b0;
    check_val("coll_ack", 32'({boot_ack, warmboot_s}), 32'd4);
    tick(3);
    check_val("coll_boot_early", 32'(warmboot_boot), 32'd0);
    tick(1);
    check_val("coll_boot", 32'({warmboot_s, warmboot_boot}), 32'd1);

    // SOF alone at timer limit clears the timer
    do_reset();
    sof_next();
    tick(9);
    sof_next();
    check_val("sof_at_limit", 32'({host_present, warmboot_s}), 32'd4);
    tick(9);
    check_val("sof_clear_gap9", 32'(warmboot_s), 32'd0);
    tick(1);
    check_val("sof_clear_timeout", 32'(warmboot_s), 32'd1);

    // supervision disabled, then async reset mid-ARM and mid-BOOT
    do_reset();
    supervise_en = 1'b0;
    tick(500);
    check_val("sup_off", 32'({warmboot_s, warmboot_boot}), 32'd0);
    supervise_en = 1'b1;
    tick(20);
    check_val("sup_on_timeout", 32'(warmboot_s), 32'd1);
    tick(2);
    reset = 1'b0;
    #1;
    check_val("arm_reset_outs", outs(), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(6);
    check_val("arm_reset_noboot", 32'({warmboot_s, warmboot_boot}), 32'd0);
    tick(20);
    check_val("reboot_boot", 32'(warmboot_boot), 32'd1);
    reset = 1'b0;
    #1;
    check_val("boot_reset_outs", outs(), 32'd0);

`ifdef USB_BOOT_SUP_FRAME_CHECK_EN
    do_reset();
    sof_frame(11'd5);
    sof_frame(11'd6);
    sof_frame(11'd8);
    check_val("frame_err_after8", 32'(frame_err_count), 32'd1);
    sof_frame(11'd9);
    check_val("frame_err_count", 32'(frame_err_count), 32'd1);
    do_reset();
    sof_frame(11'd5);
    tick(4);
    sof_frame(11'd7);
    tick(4);
    check_val("frame_bad_gap9", 32'(warmboot_s), 32'd0);
    tick(1);
    check_val("frame_bad_noclear", 32'(warmboot_s), 32'd1);
`else
    do_reset();
    sof_frame(11'd5);
    sof_frame(11'd6);
    sof_frame(11'd8);
    sof_frame(11'd9);
    check_val("frame_err_tied", 32'(frame_err_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
